multiplicador_shift_add_param: RTL
==================================

# multiplicador_shift_add_param

Sequential unsigned multiplier, N×N → 2N bits, by shift-and-add. One N-bit add per clock, computed by an internal `somador_carry_look_ahead_param #(N)` instance with `C_in` tied to 0. The block drives the adder's operands every cycle and takes its sum and carry back into the partial-product register. It is the first multi-cycle datapath built around the parameterised carry look-ahead adder.

## Interface
- `N`, default 8: operand width; the product is 2N bits; N ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  N  multiplicand; sampled with `start`.
- `B`  in  N  multiplier; sampled with `start`.
- `P`  out  2N  product register; holds the last result.
- `busy`  out  1  high while the block is in CALC.
- `done`  out  1  one-cycle pulse when `P` is updated with a new result.

## Operation
- Internal registers:
  - `M[N-1:0]`: latched multiplicand.
  - `ACC[N-1:0]`: high half of the partial product.
  - `Q[N-1:0]`: multiplier bits, which also become the low half of the partial product.
  - `CNT`: iteration counter, ⌈log2(N+1)⌉ bits.
- Adder hookup: `A = ACC`, `B = Q[0] ? M : 0`, `C_in = 0`; outputs are `{C_out, S}`.
- FSM, 3 states:
  - IDLE: on `start=1`, load `M←A`, `Q←B`, `ACC←0`, `CNT←0`, go to CALC. With `start=0`, stay in IDLE.
  - CALC: each cycle, `{ACC, Q} ← {C_out, S, Q} >> 1`, which is a right shift of the (2N+1)-bit concatenation, and `CNT←CNT+1`. When `CNT = N-1`, also load `P ← {C_out, S, Q[N-1:1]}`, which is the shifted value, and go to DONE.
  - DONE: `done=1` for exactly this one cycle, then go to IDLE unconditionally.
- Arithmetic:
  - Unsigned only; no overflow is possible, since the 2N-bit result always fits.
  - The carry out of each add must be kept as the MSB shifted into `ACC`. Dropping it is a failure.
- `start` in CALC or DONE is ignored and not queued. `A` and `B` may change freely after the sampling edge.
- `P` changes only on the transition CALC→DONE or on reset. Between results it holds its value.
- Reset values: state IDLE, `P=0`, `busy=0`, `done=0`, `ACC=Q=M=0`, `CNT=0`.
- Reset mid-operation (in CALC or DONE) aborts the multiply: no `done` pulse, `P=0`, and the block is back in IDLE on the following cycle.
- `rst` and `start` high in the same cycle: reset wins and `start` is dropped.

## Timing
- Edge E0 samples `start=1` in IDLE. `busy` is high from the cycle after E0.
- Edges E1…EN perform the N iterations. `P` is valid and `done=1` in the cycle after EN. `busy` drops in that same cycle.
- Latency from the `start` sampling edge to the `done`-high cycle is N clocks.
- Initiation interval is N+2 cycles. A new `start` is accepted at the edge that ends the DONE cycle? No: DONE always returns to IDLE, so the earliest next acceptance is the edge after the DONE cycle, one cycle after `done` was high.
- `busy` and `done` are registered outputs and are never high together.
- The adder path is purely combinational within one cycle: `ACC` and `M` → CLA → register.

## Test plan
- N=8, A=0xBB, B=0xDD, `start` pulsed for one cycle → `busy` high for 8 cycles, then `done` high for 1 cycle with P=0xA16F (187×221 = 41327).
- N=8, back-to-back requests: 0x55×0x33 → P=0x10EF, then 0xFF×0xFF → P=0xFE01. The second `start` is asserted in the cycle after `done`. Also check the carry-propagation case 0xEE×0x11 → P=0x0FCE.
- N=8, boundaries:
  - 0x00×0xFF → P=0x0000.
  - 0x01×0xFF → P=0x00FF.
  - 0x80×0x80 → P=0x4000.
  - Each result takes exactly 8 cycles to `done`.
- `start` held high continuously, A=0x03, B=0x05:
  - The first request completes with P=0x000F.
  - Operand changes while `busy` do not affect the result.
  - The next request is accepted only after DONE→IDLE.
- `rst=1` on the 4th CALC cycle of 0xBB×0xDD → `done` never pulses, P=0, `busy`=0 on the next cycle. A following 0x02×0x03 gives P=0x0006.
- N=4 instance, 0xF×0xF → P=0xE1 after 4 cycles, and 0x9×0x6 → P=0x36. Confirms the parameterisation and the CNT width.

Source files
------------

// File: rtl/multiplicador_shift_add_param.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier built around a
// parameterised carry look-ahead adder (one N-bit add per clock).

// Parameterised carry look-ahead adder: every carry is expanded from the
// generate/propagate terms and C_in rather than rippled from the previous bit.
module somador_carry_look_ahead_param #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic [N-1:0] S,
  output logic         C_out
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         prop;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]C_in
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    prop = 1'b0;
    c[0] = C_in;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & C_in);
    end
  end

  assign S     = p ^ c[N-1:0];
  assign C_out = c[N];

endmodule

module multiplicador_shift_add_param #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;

  logic [N-1:0]     add_b;
  logic [N-1:0]     sum;
  logic             c_out;

  // Add the multiplicand only when the current multiplier bit is set.
  assign add_b = q_q[0] ? m_q : '0;

  somador_carry_look_ahead_param #(
    .N (N)
  ) u_cla (
    .A     (acc_q),
    .B     (add_b),
    .C_in  (1'b0),
    .S     (sum),
    .C_out (c_out)
  );

  // Next-state logic: load in idle, shift {C_out, S, Q} right once per calc cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Carry out is kept as the new MSB of the high half.
        acc_d = {c_out, sum[N-1:1]};
        q_d   = {sum[0], q_q[N-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          p_d     = {c_out, sum, q_q[N-1:1]};
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; reset also aborts any multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);

endmodule
